// File: rtl/activation_stream_unit_if.sv
// Beat-stream bundle for activation_stream_unit: the input stream (in_*) and
// the result stream (out_*), each with valid/ready, keep and last.
interface activation_stream_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic [LANES-1:0]            in_keep;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [LANES-1:0]            out_keep;
  logic                        out_last;

  // Unit side: consumes the input stream, produces the result stream.
  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  // Environment side: drives the input stream, consumes the result stream.
  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/activation_stream_unit.sv
// Multi-lane streaming activation unit: elementwise ReLU/sigmoid/tanh/leaky with
// one output register stage, plus a buffered two-pass softmax (subtract packet max).
module activation_stream_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int MAX_ELEMS  = 256,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              func_sel,
  activation_stream_unit_if.slave s,
  output logic                    overflow,
  output logic                    busy
);
  localparam int DW     = DATA_WIDTH;
  localparam int BEAT_W = LANES * DW;
  localparam int DEPTH  = MAX_ELEMS / LANES;
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int Q      = 1 << (DW - 2);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  localparam logic signed [DW-1:0] MIN_V   = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW:0]   MIN_EXT = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] Q_P     = DW'(Q);
  localparam logic signed [DW-1:0] Q_N     = DW'(-Q);
  localparam logic signed [DW-1:0] SIG_HI  = DW'(3 * Q / 2);
  localparam logic signed [DW-1:0] SIG_MH  = DW'(Q / 2);
  localparam logic signed [DW-1:0] SIG_ML  = DW'(-(Q / 2));
  localparam logic signed [DW-1:0] SIG_LO  = DW'(-(3 * Q / 2));
  localparam logic signed [DW-1:0] TANH_HI = DW'(7 * Q / 4);
  localparam logic signed [DW-1:0] TANH_MH = DW'(3 * Q / 4);
  localparam logic signed [DW-1:0] TANH_ML = DW'(-(3 * Q / 4));
  localparam logic signed [DW-1:0] TANH_LO = DW'(-(7 * Q / 4));

  localparam logic [2:0] F_RELU  = 3'b000;
  localparam logic [2:0] F_SIG   = 3'b001;
  localparam logic [2:0] F_TANH  = 3'b010;
  localparam logic [2:0] F_SOFT  = 3'b011;
  localparam logic [2:0] F_LEAKY = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_LOAD,
    S_DRAIN,
    S_DROP
  } state_t;

  state_t                r_state;
  logic [2:0]            r_mode;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_last_idx;
  logic                  r_issued_all;
  logic                  r_drop_pending;
  logic signed [DW-1:0]  r_max;
  logic                  r_out_valid;
  logic [BEAT_W-1:0]     r_out_data;
  logic [LANES-1:0]      r_out_keep;
  logic                  r_out_last;
  logic                  r_overflow;
  logic [BEAT_W-1:0]     r_buf_data [DEPTH];
  logic [LANES-1:0]      r_buf_keep [DEPTH];

  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_out_fire;
  logic [2:0]            w_mode;
  logic                  w_pass_beat;
  logic                  w_soft_beat;
  logic                  w_drain_load;
  logic [CNT_W-1:0]      w_wr_idx;
  logic signed [DW-1:0]  w_max_next;
  logic [BEAT_W-1:0]     w_pass_data;
  logic [BEAT_W-1:0]     w_drain_data;
  logic [BEAT_W-1:0]     w_rd_word;
  logic [LANES-1:0]      w_rd_keep;
  logic signed [DW:0]    w_diff;

  // Per-lane elementwise transfer; the bands are shared by sigmoid and tanh.
  function automatic logic signed [DW-1:0] act_lane(input logic [2:0] mode,
                                                    input logic signed [DW-1:0] x);
    logic [1:0]           band;
    logic signed [DW-1:0] y;
    if (x < Q_N)       band = 2'd0;
    else if (x[DW-1])  band = 2'd1;
    else if (x < Q_P)  band = 2'd2;
    else               band = 2'd3;
    y = '0;
    case (mode)
      F_RELU:  y = x[DW-1] ? '0 : x;
      F_SIG: begin
        case (band)
          2'd0:    y = SIG_LO;
          2'd1:    y = SIG_ML;
          2'd2:    y = SIG_MH;
          default: y = SIG_HI;
        endcase
      end
      F_TANH: begin
        case (band)
          2'd0:    y = TANH_LO;
          2'd1:    y = TANH_ML;
          2'd2:    y = TANH_MH;
          default: y = TANH_HI;
        endcase
      end
      F_LEAKY: y = x[DW-1] ? (x >>> LEAK_SHIFT) : x;
      default: y = '0;
    endcase
    return y;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_PASS: w_in_ready = !r_out_valid || s.out_ready;
      S_LOAD, S_DROP: w_in_ready = 1'b1;
      default:        w_in_ready = 1'b0;
    endcase
  end

  assign w_acc        = s.in_valid && w_in_ready;
  assign w_out_fire   = r_out_valid && s.out_ready;
  assign w_mode       = (r_state == S_IDLE) ? func_sel : r_mode;
  assign w_pass_beat  = w_acc && (((r_state == S_IDLE) && (func_sel != F_SOFT)) ||
                                  (r_state == S_PASS));
  assign w_soft_beat  = w_acc && (((r_state == S_IDLE) && (func_sel == F_SOFT)) ||
                                  (r_state == S_LOAD));
  assign w_drain_load = (r_state == S_DRAIN) && !r_issued_all &&
                        (!r_out_valid || s.out_ready);
  assign w_wr_idx     = (r_state == S_IDLE) ? '0 : r_wr_cnt;

  always_comb begin
    w_pass_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s.in_keep[i]) w_pass_data[i*DW +: DW] = act_lane(w_mode, s.in_data[i*DW +: DW]);
    end
  end

  // The first beat of a softmax packet restarts the running max from MIN.
  always_comb begin
    w_max_next = (r_state == S_IDLE) ? MIN_V : r_max;
    for (int i = 0; i < LANES; i++) begin
      if (s.in_keep[i] && ($signed(s.in_data[i*DW +: DW]) > w_max_next))
        w_max_next = s.in_data[i*DW +: DW];
    end
  end

  // x - max is never positive, so only the negative rail needs clamping.
  always_comb begin
    w_rd_word    = r_buf_data[r_rd_cnt];
    w_rd_keep    = r_buf_keep[r_rd_cnt];
    w_drain_data = '0;
    w_diff       = '0;
    for (int i = 0; i < LANES; i++) begin
      w_diff = $signed({w_rd_word[i*DW+DW-1], w_rd_word[i*DW +: DW]}) -
               $signed({r_max[DW-1], r_max});
      if (w_rd_keep[i]) w_drain_data[i*DW +: DW] = (w_diff < MIN_EXT) ? MIN_V : w_diff[DW-1:0];
    end
  end

  // NOTE: the packet buffer has no reset; a slot is always written before it is drained.
  always_ff @(posedge clk) begin
    if (w_soft_beat) begin
      r_buf_data[w_wr_idx] <= s.in_data;
      r_buf_keep[w_wr_idx] <= s.in_keep;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_mode         <= F_RELU;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_last_idx     <= '0;
      r_issued_all   <= 1'b0;
      r_drop_pending <= 1'b0;
      r_max          <= MIN_V;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_keep     <= '0;
      r_out_last     <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_out_fire) r_out_valid <= 1'b0;
      if (w_acc && (r_state == S_IDLE)) r_mode <= func_sel;

      if (w_pass_beat) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pass_data;
        r_out_keep  <= s.in_keep;
        r_out_last  <= s.in_last;
        r_state     <= s.in_last ? S_IDLE : S_PASS;
      end

      if (w_soft_beat) begin
        r_max <= w_max_next;
        if (s.in_last || (w_wr_idx == LAST_SLOT)) begin
          // A full buffer without in_last forces the drain and drops the remainder.
          r_state        <= S_DRAIN;
          r_last_idx     <= w_wr_idx;
          r_rd_cnt       <= '0;
          r_issued_all   <= 1'b0;
          r_wr_cnt       <= '0;
          r_overflow     <= !s.in_last;
          r_drop_pending <= !s.in_last;
        end else begin
          r_state  <= S_LOAD;
          r_wr_cnt <= w_wr_idx + CNT_W'(1);
        end
      end

      if (w_drain_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_drain_data;
        r_out_keep  <= w_rd_keep;
        r_out_last  <= (r_rd_cnt == r_last_idx);
        r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
        if (r_rd_cnt == r_last_idx) r_issued_all <= 1'b1;
      end

      if ((r_state == S_DRAIN) && w_out_fire && r_out_last) begin
        r_state        <= r_drop_pending ? S_DROP : S_IDLE;
        r_drop_pending <= 1'b0;
      end

      if ((r_state == S_DROP) && w_acc && s.in_last) r_state <= S_IDLE;
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_keep  = r_out_keep;
  assign s.out_last  = r_out_last;
  assign overflow    = r_overflow;
  assign busy        = (r_state == S_LOAD) || (r_state == S_DRAIN);
endmodule

// File: tb/tb_activation_stream_unit.sv
// Scoreboard bench for activation_stream_unit: stimulus pushes expected beats,
// a negedge monitor pops and compares every output handshake.
module tb_activation_stream_unit;
  localparam int DW    = 8;
  localparam int LN    = 4;
  localparam int ME    = 256;
  localparam int DEPTH = ME / LN;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] func_sel = 3'b000;
  logic       overflow;
  logic       busy;

  activation_stream_unit_if #(.DATA_WIDTH(DW), .LANES(LN)) ifc();

  activation_stream_unit #(
    .DATA_WIDTH(DW),
    .LANES     (LN),
    .MAX_ELEMS (ME),
    .LEAK_SHIFT(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .func_sel(func_sel),
    .s       (ifc.slave),
    .overflow(overflow),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  beat_t       got;
  int          n_total = 0;
  int          n_bad   = 0;
  int          pops    = 0;
  int          acc_cnt = 0;
  int          ovf_cnt = 0;
  int          ovf_acc = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_beat  = '0;
  logic        sdone;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: got timeout want completion", name);
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int ref_relu(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int ovf_val(input int k, input int i);
    return ((k * 7) % 50) - 20 + i * 5;
  endfunction

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Called between posedge+1 and the next negedge; returns at posedge+1 after acceptance.
  task automatic send(input logic [2:0] fs, input logic [31:0] d, input logic [3:0] k,
                      input logic l);
    int g = 0;
    func_sel     = fs;
    ifc.in_data  = d;
    ifc.in_keep  = k;
    ifc.in_last  = l;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!ifc.in_ready) begin
      timeout_fail("send_ready");
      ifc.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 2000) begin
      timeout_fail("drain");
      exp_q.delete();
    end
  endtask

  // Monitor: stall stability, overflow pulses, accept count, scoreboard compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) begin
        ovf_cnt++;
        ovf_acc = acc_cnt;
      end
      if (prev_stall && ifc.out_valid)
        check("stall_hold", {ifc.out_data, ifc.out_keep, ifc.out_last}, prev_beat);
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev_beat  = {ifc.out_data, ifc.out_keep, ifc.out_last};
      if (ifc.in_valid && ifc.in_ready) acc_cnt++;
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {ifc.out_data, ifc.out_keep, ifc.out_last}, '0);
        end else begin
          got = exp_q.pop_front();
          check("out_data", ifc.out_data, got.data);
          check("out_keep", ifc.out_keep, got.keep);
          check("out_last", ifc.out_last, got.last);
          pops++;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int mx;
    int acc_base;
    int pop_base;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_keep   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    sdone         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_keep", ifc.out_keep, 0);
    check("rst_out_last", ifc.out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", ifc.in_ready, 1);

    // Back-to-back single-beat elementwise packets.
    expect_beat(pk(0, 0, 0, 127), 4'hF, 1'b1);
    send(3'b000, pk(-128, -1, 0, 127), 4'hF, 1'b1);
    check("relu_latency", ifc.out_valid, 1);
    expect_beat(pk(-96, -32, 32, 96), 4'hF, 1'b1);
    send(3'b001, pk(-65, -64, 63, 64), 4'hF, 1'b1);
    expect_beat(pk(-112, -48, 48, 112), 4'hF, 1'b1);
    send(3'b010, pk(-65, -64, 63, 64), 4'hF, 1'b1);
    expect_beat(pk(-1, -1, 5, -16), 4'hF, 1'b1);
    send(3'b100, pk(-8, -1, 5, -128), 4'hF, 1'b1);
    expect_beat(pk(0, 6, 7, 0), 4'b0110, 1'b1);
    send(3'b000, pk(5, 6, 7, -8), 4'b0110, 1'b1);
    expect_beat(pk(0, 0, 0, 0), 4'hF, 1'b1);
    send(3'b101, pk(1, 2, 3, 4), 4'hF, 1'b1);
    wait_drain();

    // Two-beat softmax: max 30, -158 clamps to -128.
    expect_beat(pk(-20, -10, -128, -25), 4'hF, 1'b0);
    expect_beat(pk(0, 0, 0, 0), 4'b0001, 1'b1);
    send(3'b011, pk(10, 20, -128, 5), 4'hF, 1'b0);
    send(3'b011, pk(30, 0, 0, 0), 4'b0001, 1'b1);
    check("drain_busy", busy, 1);
    check("drain_in_ready", ifc.in_ready, 0);
    wait_drain();
    check("idle_after_drain", busy, 0);

    // ReLU stream under toggling backpressure; func_sel changes mid-packet.
    for (int k = 0; k < 8; k++)
      expect_beat(pk(ref_relu(k * 20 - 70), ref_relu(-k * 3), ref_relu(127 - k),
                     ref_relu(k - 4)), 4'hF, k == 7);
    sdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send((k == 0) ? 3'b000 : ((k % 2 == 1) ? 3'b011 : 3'b001),
               pk(k * 20 - 70, -k * 3, 127 - k, k - 4), 4'hF, k == 7);
        sdone = 1'b1;
      end
      begin
        while (!sdone) begin
          @(posedge clk);
          #1;
          ifc.out_ready = ~ifc.out_ready;
        end
      end
    join
    ifc.out_ready = 1'b1;
    wait_drain();

    // Softmax overflow: DEPTH+3 beats, DEPTH drained, 3 dropped.
    mx = -128;
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < 4; i++)
        if (ovf_val(k, i) > mx) mx = ovf_val(k, i);
    for (int k = 0; k < DEPTH; k++)
      expect_beat(pk(ovf_val(k, 0) - mx, ovf_val(k, 1) - mx, ovf_val(k, 2) - mx,
                     ovf_val(k, 3) - mx), 4'hF, k == DEPTH - 1);
    ovf_cnt  = 0;
    acc_base = acc_cnt;
    for (int k = 0; k < DEPTH + 3; k++)
      send(3'b011, pk(ovf_val(k, 0), ovf_val(k, 1), ovf_val(k, 2), ovf_val(k, 3)),
           4'hF, k == DEPTH + 2);
    wait_drain();
    check("ovf_pulses", ovf_cnt, 1);
    check("ovf_at_beat", ovf_acc - acc_base, DEPTH);
    check("ovf_accepted", acc_cnt - acc_base, DEPTH + 3);
    expect_beat(pk(0, 3, 0, 4), 4'hF, 1'b1);
    send(3'b000, pk(-3, 3, -4, 4), 4'hF, 1'b1);
    wait_drain();

    // Reset during drain after two output handshakes.
    for (int k = 0; k < 5; k++)
      expect_beat(pk(4 * k + 1 - 20, 4 * k + 2 - 20, 4 * k + 3 - 20, 4 * k + 4 - 20),
                  4'hF, k == 4);
    pop_base = pops;
    for (int k = 0; k < 5; k++)
      send(3'b011, pk(4 * k + 1, 4 * k + 2, 4 * k + 3, 4 * k + 4), 4'hF, k == 4);
    for (int g = 0; g < 50 && pops < pop_base + 2; g++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_pops", pops - pop_base, 2);
    check("pre_rst_busy", busy, 1);
    ifc.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", ifc.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", ifc.in_ready, 1);
    rst = 1'b0;
    exp_q.delete();
    ifc.out_ready = 1'b1;

    // Fresh softmax after reset: max must be this packet's own.
    expect_beat(pk(0, -10, -20, -30), 4'hF, 1'b1);
    send(3'b011, pk(-50, -60, -70, -80), 4'hF, 1'b1);
    wait_drain();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
